// File: rtl/rtc_bus_arbiter.sv
// Arbiter and transaction sequencer for the multiplexed address/data bus to the RTC chip.
// Grants one of irq/wr/rd per idle cycle and runs an address phase plus a data phase with gaps.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | bus released; arbitration between pending requests
// ADDR   | address phase: cs_n/wr_n low, ale high, address driven
// GAP1   | turnaround after address; bus keeps driving only for writes
// DATA   | data phase: wr_n (write) or rd_n (read) low
// GAP2   | turnaround after data; all strobes inactive, bus released
// DONE   | one-cycle completion pulse, read byte published
module rtc_bus_arbiter #(
  parameter int unsigned T_PULSE    = 4,
  parameter int unsigned T_GAP      = 2,
  parameter int unsigned MAX_WR_RUN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_irq,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr_irq,
  input  logic [7:0] addr_wr,
  input  logic [7:0] addr_rd,
  input  logic [7:0] wdata_irq,
  input  logic [7:0] wdata_wr,
  output logic [2:0] gnt,
  output logic       done_irq,
  output logic       done_wr,
  output logic       done_rd,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ale,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
  localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);
  localparam logic [3:0] RUN_MAX  = 4'(MAX_WR_RUN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_GAP1,
    S_DATA,
    S_GAP2,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] run, run_nxt;
  logic [2:0] win, gnt_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic       is_wr, wr_nxt;
  logic [7:0] cap;

  logic       cs_n_nxt, rd_n_nxt, wr_n_nxt, ale_nxt, ad_oe_nxt;
  logic [7:0] ad_out_nxt;

  // A read that has waited through RUN_MAX write grants jumps ahead of writes.
  always_comb begin
    win = 3'b000;
    if (req_irq)
      win = 3'b100;
    else if (req_wr && !(req_rd && run == RUN_MAX))
      win = 3'b010;
    else if (req_rd)
      win = 3'b001;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    run_nxt   = run;
    gnt_nxt   = gnt;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    wr_nxt    = is_wr;
    case (state)
      S_IDLE: begin
        gnt_nxt = win;
        if (win[2])
          run_nxt = run;
        else if (win[1] && req_rd)
          run_nxt = (run == RUN_MAX) ? run : run + 4'd1;
        else
          run_nxt = 4'd0;
        if (win != 3'b000) begin
          state_nxt = S_ADDR;
          cnt_nxt   = PULSE_LD;
          wr_nxt    = !win[0];
          if (win[2]) begin
            addr_nxt = addr_irq;
            data_nxt = wdata_irq;
          end else if (win[1]) begin
            addr_nxt = addr_wr;
            data_nxt = wdata_wr;
          end else begin
            addr_nxt = addr_rd;
          end
        end
      end
      S_ADDR: begin
        if (cnt == 4'd0) begin
          state_nxt = S_GAP1;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP1: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DATA;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DATA: begin
        if (cnt == 4'd0) begin
          state_nxt = S_GAP2;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_GAP2: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
        gnt_nxt   = 3'b000;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
        gnt_nxt   = 3'b000;
      end
    endcase
  end

  // Pins are decoded from the next state so they change together with the state register.
  always_comb begin
    cs_n_nxt   = 1'b1;
    rd_n_nxt   = 1'b1;
    wr_n_nxt   = 1'b1;
    ale_nxt    = 1'b0;
    ad_oe_nxt  = 1'b0;
    ad_out_nxt = ad_out;
    case (state_nxt)
      S_ADDR: begin
        cs_n_nxt   = 1'b0;
        wr_n_nxt   = 1'b0;
        ale_nxt    = 1'b1;
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = addr_nxt;
      end
      S_GAP1: ad_oe_nxt = wr_nxt;
      S_DATA: begin
        cs_n_nxt = 1'b0;
        if (wr_nxt) begin
          wr_n_nxt   = 1'b0;
          ad_oe_nxt  = 1'b1;
          ad_out_nxt = data_nxt;
        end else begin
          rd_n_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      run         <= 4'd0;
      gnt         <= 3'b000;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      is_wr       <= 1'b0;
      cap         <= 8'd0;
      rdata       <= 8'd0;
      rdata_valid <= 1'b0;
      done_irq    <= 1'b0;
      done_wr     <= 1'b0;
      done_rd     <= 1'b0;
      busy        <= 1'b0;
      cs_n        <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      ale         <= 1'b0;
      ad_oe       <= 1'b0;
      ad_out      <= 8'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      run    <= run_nxt;
      gnt    <= gnt_nxt;
      addr_q <= addr_nxt;
      data_q <= data_nxt;
      is_wr  <= wr_nxt;
      if (state == S_DATA && cnt == 4'd0 && !is_wr)
        cap <= ad_in;
      if (state_nxt == S_DONE && !is_wr)
        rdata <= cap;
      rdata_valid <= (state_nxt == S_DONE) && !is_wr;
      {done_irq, done_wr, done_rd} <= (state_nxt == S_DONE) ? gnt : 3'b000;
      busy   <= (state_nxt != S_IDLE);
      cs_n   <= cs_n_nxt;
      rd_n   <= rd_n_nxt;
      wr_n   <= wr_n_nxt;
      ale    <= ale_nxt;
      ad_oe  <= ad_oe_nxt;
      ad_out <= ad_out_nxt;
    end
  end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Cycle k of a transaction is the k-th cycle after the idle cycle in which the request was seen.
module tb_rtc_bus_arbiter;

  localparam int TP     = 4;
  localparam int TG     = 2;
  localparam int MAXRUN = 2;
  localparam int LAT    = 2 * TP + 2 * TG + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_irq = 1'b0, req_wr = 1'b0, req_rd = 1'b0;
  logic [7:0] addr_irq = '0, addr_wr = '0, addr_rd = '0;
  logic [7:0] wdata_irq = '0, wdata_wr = '0, ad_in = '0;
  logic [2:0] gnt;
  logic       done_irq, done_wr, done_rd, rdata_valid, busy;
  logic       cs_n, rd_n, wr_n, ale, ad_oe;
  logic [7:0] rdata, ad_out;

  int n_tests = 0;
  int n_fail  = 0;

  rtc_bus_arbiter #(.T_PULSE(TP), .T_GAP(TG), .MAX_WR_RUN(MAXRUN)) dut (
    .clk(clk), .rst(rst),
    .req_irq(req_irq), .req_wr(req_wr), .req_rd(req_rd),
    .addr_irq(addr_irq), .addr_wr(addr_wr), .addr_rd(addr_rd),
    .wdata_irq(wdata_irq), .wdata_wr(wdata_wr),
    .gnt(gnt), .done_irq(done_irq), .done_wr(done_wr), .done_rd(done_rd),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ale(ale),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  wire [4:0] ctl = {cs_n, rd_n, wr_n, ale, ad_oe};
  wire [2:0] dn  = {done_irq, done_wr, done_rd};

  // Expected {cs_n, rd_n, wr_n, ale, ad_oe} at cycle t of a transaction (t=0: idle).
  function automatic logic [4:0] exp_ctl(int t, bit wr);
    if (t >= 1 && t <= TP) return 5'b01011;
    if (t > TP && t <= TP + TG) return {4'b1110, wr};
    if (t > TP + TG && t <= 2 * TP + TG) return wr ? 5'b01001 : 5'b00100;
    return 5'b11100;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ctl, gnt, dn, rdata_valid, rdata, busy, ad_out} !== {5'b11100, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00})
      $display("FAIL reset_values: got %b expected %b",
               {ctl, gnt, dn, rdata_valid, rdata, busy, ad_out},
               {5'b11100, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00});
    if ({ctl, gnt, dn, rdata_valid, rdata, busy, ad_out} !== {5'b11100, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 8'h00})
      n_fail++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || gnt !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b gnt=%b expected 0/000", busy, gnt);
    end
  endtask

  // One isolated read (is_rd=1) or write; inputs change after grant to show they are latched.
  task automatic test_single(input bit is_rd);
    logic [7:0] a, d, exp_rdata;
    logic [2:0] g;
    a = is_rd ? 8'h21 : 8'h22;
    d = 8'h30;
    g = is_rd ? 3'b001 : 3'b010;
    exp_rdata = 8'h45;
    addr_rd = a; addr_wr = a; wdata_wr = d; ad_in = 8'hEE;
    req_rd = is_rd; req_wr = !is_rd;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k <= LAT) begin
        n_tests++;
        if ({ctl, gnt, busy} !== {exp_ctl(k, !is_rd), g, 1'b1}) begin
          n_fail++;
          $display("FAIL single_%s_pins k=%0d: got %b expected %b", is_rd ? "rd" : "wr", k,
                   {ctl, gnt, busy}, {exp_ctl(k, !is_rd), g, 1'b1});
        end
      end
      if (k <= TP || (!is_rd && k > TP + TG && k <= 2 * TP + TG)) begin
        n_tests++;
        if (ad_out !== ((k <= TP) ? a : d)) begin
          n_fail++;
          $display("FAIL single_ad_out k=%0d: got %h expected %h", k, ad_out, (k <= TP) ? a : d);
        end
      end
      n_tests++;
      if ({dn, rdata_valid} !== ((k == LAT) ? {g, is_rd} : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_done k=%0d: got %b expected %b", k, {dn, rdata_valid},
                 (k == LAT) ? {g, is_rd} : 4'b0000);
      end
      if (k == LAT) begin
        n_tests++;
        if (rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL single_rdata: got %h expected %h", rdata, exp_rdata);
        end
        req_rd = 1'b0; req_wr = 1'b0;
      end
      if (k == LAT + 1) begin
        n_tests++;
        if ({busy, gnt, ctl} !== {1'b0, 3'b000, 5'b11100}) begin
          n_fail++;
          $display("FAIL single_release: got %b expected %b", {busy, gnt, ctl}, {1'b0, 3'b000, 5'b11100});
        end
      end
      if (k == 1) begin
        addr_rd = ~a; addr_wr = ~a; wdata_wr = ~d;
      end
      ad_in = (k >= TP + TG + 1 && k <= 2 * TP + TG) ? 8'h45 : 8'hEE;
    end
  endtask

  task automatic test_priority();
    int t_irq, t_wr, t_rd;
    t_irq = -1; t_wr = -1; t_rd = -1;
    addr_irq = 8'h0A; wdata_irq = 8'h01; addr_wr = 8'h0B; wdata_wr = 8'h02; addr_rd = 8'h0C;
    req_irq = 1'b1; req_wr = 1'b1; req_rd = 1'b1;
    for (int k = 1; k <= 3 * (LAT + 1) + 2; k++) begin
      @(negedge clk);
      if (k == 1 || k == LAT + 2 || k == 2 * LAT + 3) begin
        n_tests++;
        if (gnt !== ((k == 1) ? 3'b100 : (k == LAT + 2) ? 3'b010 : 3'b001)) begin
          n_fail++;
          $display("FAIL priority_gnt k=%0d: got %b expected %b", k, gnt,
                   (k == 1) ? 3'b100 : (k == LAT + 2) ? 3'b010 : 3'b001);
        end
      end
      if (k == 1) begin
        n_tests++;
        if (ad_out !== 8'h0A) begin
          n_fail++;
          $display("FAIL priority_irq_addr: got %h expected 0a", ad_out);
        end
      end
      if (done_irq && t_irq < 0) begin t_irq = k; req_irq = 1'b0; end
      if (done_wr && t_wr < 0)   begin t_wr = k;  req_wr = 1'b0;  end
      if (done_rd && t_rd < 0)   begin t_rd = k;  req_rd = 1'b0;  end
    end
    req_irq = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
    n_tests++;
    if (t_irq != LAT || t_wr != 2 * LAT + 1 || t_rd != 3 * LAT + 2) begin
      n_fail++;
      $display("FAIL priority_done_cycles: got %0d/%0d/%0d expected %0d/%0d/%0d",
               t_irq, t_wr, t_rd, LAT, 2 * LAT + 1, 3 * LAT + 2);
    end
  endtask

  task automatic test_anti_starvation();
    logic [2:0] seq[$];
    logic       prev_busy;
    int         budget;
    prev_busy = 1'b0;
    budget = 6 * (LAT + 1) + 10;
    req_wr = 1'b1; req_rd = 1'b1; addr_wr = 8'h40; addr_rd = 8'h41;
    while (seq.size() < 6 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (busy && !prev_busy) seq.push_back(gnt);
      prev_busy = busy;
    end
    req_wr = 1'b0; req_rd = 1'b0;
    n_tests++;
    if (seq.size() != 6) begin
      n_fail++;
      $display("FAIL starvation_timeout: got %0d grants expected 6", seq.size());
    end
    for (int i = 0; i < seq.size(); i++) begin
      n_tests++;
      if (seq[i] !== ((i % 3 == 2) ? 3'b001 : 3'b010)) begin
        n_fail++;
        $display("FAIL starvation_order[%0d]: got %b expected %b", i, seq[i],
                 (i % 3 == 2) ? 3'b001 : 3'b010);
      end
    end
    budget = 2 * LAT;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL starvation_drain: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_withdrawn();
    logic [7:0] exp_cap;
    bit         extra;
    exp_cap = 8'h00;
    extra = 1'b0;
    addr_rd = 8'h5A; req_rd = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      n_tests++;
      if ({ctl, gnt} !== {exp_ctl(k, 1'b0), 3'b001}) begin
        n_fail++;
        $display("FAIL withdrawn_pins k=%0d: got %b expected %b", k, {ctl, gnt}, {exp_ctl(k, 1'b0), 3'b001});
      end
      if (k == 3) req_rd = 1'b0;
      ad_in = 8'($urandom);
      if (k == 2 * TP + TG) exp_cap = ad_in;
    end
    n_tests++;
    if ({done_rd, rdata_valid, rdata} !== {1'b1, 1'b1, exp_cap}) begin
      n_fail++;
      $display("FAIL withdrawn_done: got %b expected %b", {done_rd, rdata_valid, rdata}, {1'b1, 1'b1, exp_cap});
    end
    for (int k = 0; k < LAT + 1; k++) begin
      @(negedge clk);
      if (busy || gnt != 3'b000 || dn != 3'b000) extra = 1'b1;
    end
    n_tests++;
    if (extra) begin
      n_fail++;
      $display("FAIL withdrawn_regrant: got activity after done expected none");
    end
  endtask

  task automatic test_mid_reset();
    bit extra;
    extra = 1'b0;
    addr_wr = 8'h33; wdata_wr = 8'h44; req_wr = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ctl, gnt, busy, dn, rdata_valid, rdata} !== {5'b11100, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_reset: got %b expected %b", {ctl, gnt, busy, dn, rdata_valid, rdata},
               {5'b11100, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00});
    end
    rst = 1'b1; req_wr = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (busy || dn != 3'b000) extra = 1'b1;
    end
    n_tests++;
    if (extra) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got activity after reset expected none");
    end
  endtask

  // Requesters raise at random and hold until their done; the model tracks whole transactions.
  task automatic test_random();
    int         m_t, m_run, budget;
    bit         m_wr;
    logic [2:0] m_who, e_gnt, e_dn;
    logic [7:0] m_addr, m_data, m_cap, m_rdata;
    m_t = 0; m_run = 0; m_wr = 1'b0; m_who = 3'b000;
    m_addr = '0; m_data = '0; m_cap = '0; m_rdata = 8'h00;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      e_gnt = (m_t != 0) ? m_who : 3'b000;
      e_dn  = (m_t == LAT) ? m_who : 3'b000;
      n_tests++;
      if ({gnt, busy, dn, rdata_valid, rdata} !== {e_gnt, m_t != 0, e_dn, (m_t == LAT) && !m_wr, m_rdata}) begin
        n_fail++;
        $display("FAIL rand_status c=%0d: got %b expected %b", c, {gnt, busy, dn, rdata_valid, rdata},
                 {e_gnt, m_t != 0, e_dn, (m_t == LAT) && !m_wr, m_rdata});
      end
      n_tests++;
      if (ctl !== exp_ctl(m_t, m_wr)) begin
        n_fail++;
        $display("FAIL rand_pins c=%0d t=%0d: got %b expected %b", c, m_t, ctl, exp_ctl(m_t, m_wr));
      end
      if ((m_t >= 1 && m_t <= TP) || (m_wr && m_t > TP + TG && m_t <= 2 * TP + TG)) begin
        n_tests++;
        if (ad_out !== ((m_t <= TP) ? m_addr : m_data)) begin
          n_fail++;
          $display("FAIL rand_ad_out c=%0d: got %h expected %h", c, ad_out, (m_t <= TP) ? m_addr : m_data);
        end
      end
      n_tests++;
      if ((!cs_n && !rd_n && !wr_n) || (ad_oe && !rd_n)) begin
        n_fail++;
        $display("FAIL rand_bus_conflict c=%0d: got %b expected no overlap", c, ctl);
      end
      if (m_t == LAT) begin
        if (m_who[2]) req_irq = 1'b0;
        if (m_who[1]) req_wr = 1'b0;
        if (m_who[0]) req_rd = 1'b0;
      end
      if (!req_irq && $urandom_range(0, 15) == 0) req_irq = 1'b1;
      if (!req_wr && $urandom_range(0, 3) == 0) req_wr = 1'b1;
      if (!req_rd && $urandom_range(0, 3) == 0) req_rd = 1'b1;
      addr_irq = 8'($urandom); addr_wr = 8'($urandom); addr_rd = 8'($urandom);
      wdata_irq = 8'($urandom); wdata_wr = 8'($urandom); ad_in = 8'($urandom);
      if (m_t == LAT) begin
        m_t = 0;
      end else if (m_t != 0) begin
        if (m_t == 2 * TP + TG && !m_wr) m_cap = ad_in;
        if (m_t == LAT - 1 && !m_wr) m_rdata = m_cap;
        m_t++;
      end else if (req_irq) begin
        m_who = 3'b100; m_wr = 1'b1; m_addr = addr_irq; m_data = wdata_irq; m_t = 1;
      end else if (req_wr && !(req_rd && m_run == MAXRUN)) begin
        m_who = 3'b010; m_wr = 1'b1; m_addr = addr_wr; m_data = wdata_wr; m_t = 1;
        m_run = req_rd ? ((m_run + 1 > MAXRUN) ? MAXRUN : m_run + 1) : 0;
      end else if (req_rd) begin
        m_who = 3'b001; m_wr = 1'b0; m_addr = addr_rd; m_t = 1; m_run = 0;
      end else begin
        m_run = 0;
      end
    end
    req_irq = 1'b0; req_wr = 1'b0; req_rd = 1'b0;
    budget = 2 * LAT;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b1);
    test_single(1'b0);
    test_priority();
    test_anti_starvation();
    test_withdrawn();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
